demux1x4_stream: RTL and testbench
==================================

# demux1x4_stream

Registered 1-to-4 stream demultiplexer: the inverse of the 1-bit 4:1 select mux used in the cosine LUT datapath. It accepts one sample per cycle on a valid/ready input and routes it, by a 2-bit lane select, into one of four output lanes. Each lane has its own holding register and valid/ready handshake. It sits in the functional-link expansion path, distributing input samples to the four per-branch cosine/LUT lanes.

## Interface
Parameters:
- `WIDTH`, 16, sample width in bits.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  input sample.
- `in_sel`  in  2  destination lane (0..3); ignored when `DEMUX_AUTO_SEL_EN` is defined.
- `in_valid`  in  1  input sample present.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `out_data`  out  4*WIDTH  lane i occupies bits `[i*WIDTH +: WIDTH]`.
- `out_valid`  out  4  per-lane data valid.
- `out_ready`  in  4  per-lane downstream ready.
- `xfer_cnt`  out  8  count of accepted input transfers, wraps 255→0.

## Operation
- Effective select `sel`:
  - Without the macro, `sel = in_sel`.
  - With the macro, `sel = rr_ptr`.
- Each lane i is a one-entry register holding `data_i` and `valid_i`. Outputs `out_valid[i] = valid_i` and `out_data` lane i `= data_i`.
- Lane i can load when `!valid_i || out_ready[i]`.
- `in_ready` = load condition of lane `sel`. This is combinational from `out_ready[sel]` and `valid_sel`.
- Accept = `in_valid && in_ready`. On accept:
  - `data_sel <= in_data` and `valid_sel <= 1`.
  - `xfer_cnt` increments.
- Lane drain: if `valid_i && out_ready[i]` and the lane is not loaded this cycle, then `valid_i <= 0`. `data_i` holds its last value.
- Simultaneous drain and load on the same lane: the lane stays valid with the new data. There is no bubble, so throughput is 1 sample/cycle.
- Non-selected lanes drain independently in the same cycle as an accept on another lane.
- Input protocol: `in_data` and `in_sel` are stable while `in_valid && !in_ready`. The block does not check this. `in_valid` may deassert freely when not accepted.
- Only one lane loads per cycle. The block holds no other state and has no FSM beyond the lane valid bits, the counter and `rr_ptr`.

## Timing
- Reset, asynchronous, any time (including mid-transfer):
  - `out_valid = 4'b0000`, all `out_data = 0`, `xfer_cnt = 0`, `rr_ptr = 0`.
  - `in_ready` reads 1 during and immediately after reset, since all lanes are empty.
  - Any pending lane data is discarded.
- Latency: a sample accepted at rising edge k appears on its lane with `out_valid` high after edge k, i.e. 1 cycle.
- A lane holds `out_valid` and data stable until the edge where `out_ready[i]` is sampled high.
- Full lane with `out_ready[sel] = 0`: `in_ready = 0`, and there is no accept. Other lanes are unaffected.
- `xfer_cnt` wraps from 255 to 0 on the 256th accept with no flag. It updates on the same edge as the lane load.

## Configuration
- `DEMUX_AUTO_SEL_EN` defined:
  - `in_sel` is ignored.
  - An internal 2-bit `rr_ptr` drives selection and advances 0→1→2→3→0 on each accept only.
  - A stall on a full lane blocks the input. There is no skipping to a free lane.
- Not defined: `rr_ptr` is not built and lane choice comes solely from `in_sel`.

## Test plan
- Reset then single beat: `in_sel=2`, `in_data=16'h1234`, `in_valid=1` for one cycle, `out_ready=4'hF`. Required:
  - Next cycle `out_valid=4'b0100` and lane 2 reads `16'h1234`.
  - The following cycle `out_valid=0` and `xfer_cnt=1`.
- Back-pressure: lane 1 loaded with `16'hAAAA` while `out_ready[1]=0`, then a second beat with `in_sel=1`. Required:
  - `in_ready=0` and lane 1 still holds `16'hAAAA`.
  - Raising `out_ready[1]` gives `in_ready=1` the same cycle, and lane 1 is replaced by the new data with no bubble.
- Independent lanes: lane 0 stalled (`out_ready[0]=0`), beats sent to lanes 3 and 2. Both are accepted on consecutive cycles, and lane 0 data is unchanged.
- Counter wrap: 256 accepted beats with `out_ready=4'hF`. Required `xfer_cnt=0` after the last, and 255 one beat earlier.
- Async reset mid-stream: assert `rst_n=0` between edges with lanes 0 and 3 valid. Required:
  - `out_valid=0` and `out_data=0` immediately, without waiting for a clock edge.
  - `in_ready=1`.
- With `DEMUX_AUTO_SEL_EN`: 5 beats `16'h0001`..`16'h0005` with `in_sel` held at 0. Required:
  - Beats land in lanes 0, 1, 2, 3, 0 in that order.
  - A stall on lane 1 holds `rr_ptr` at 1 until that lane drains.

Source files
------------

// File: rtl/demux1x4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with a one-entry holding register per lane.
// Define DEMUX_AUTO_SEL_EN to replace in_sel with an internal round-robin lane pointer.
module demux1x4_stream #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [7:0]         xfer_cnt
);

    logic [1:0]         sel;
    logic               accept;
    logic [3:0]         valid_q, valid_d;
    logic [4*WIDTH-1:0] data_q;
    logic [7:0]         cnt_q;

`ifdef DEMUX_AUTO_SEL_EN
    logic [1:0] rr_ptr_q;
    logic       unused_sel;

    assign sel        = rr_ptr_q;
    assign unused_sel = ^in_sel;

    // No skipping: a full target lane stalls the input until it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 2'd0;
        end else if (accept) begin
            rr_ptr_q <= rr_ptr_q + 2'd1;
        end
    end
`else
    assign sel = in_sel;
`endif

    assign in_ready = !valid_q[sel] || out_ready[sel];
    assign accept   = in_valid && in_ready;

    // Drain first, then let a load override so drain+load on one lane has no bubble.
    always_comb begin
        valid_d = valid_q & ~out_ready;
        if (accept) begin
            valid_d[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
            data_q  <= '0;
            cnt_q   <= 8'd0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                cnt_q <= cnt_q + 8'd1;
            end
            for (int i = 0; i < 4; i++) begin
                if (accept && sel == 2'(i)) begin
                    data_q[i*WIDTH +: WIDTH] <= in_data;
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux1x4_stream.sv
// Self-checking bench for demux1x4_stream: directed scenarios plus random traffic
// compared against a transaction-level lane model.
module tb_demux1x4_stream;

    localparam int W = 16;
`ifdef DEMUX_AUTO_SEL_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   in_data;
    logic [1:0]     in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [7:0]     xfer_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what each lane holds, total accepts, next auto lane.
    logic [W-1:0] m_data [4];
    bit           m_valid[4];
    int           m_cnt;
    int           m_rr;

    demux1x4_stream #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
        end
        m_cnt = 0;
        m_rr  = 0;
    endfunction

    function automatic int model_sel();
        return AUTO ? m_rr : int'(in_sel);
    endfunction

    function automatic bit model_ready();
        int s = model_sel();
        return !m_valid[s] || out_ready[s];
    endfunction

    function automatic logic [3:0] model_valid_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic logic [W-1:0] lane(input int i);
        return out_data[i*W +: W];
    endfunction

    task automatic drive(input logic [W-1:0] d, input logic [1:0] s, input logic v,
                         input logic [3:0] r);
        in_data   = d;
        in_sel    = s;
        in_valid  = v;
        out_ready = r;
    endtask

    // Advance one clock and apply the transfer rules to the model.
    task automatic tick();
        int           s;
        bit           acc;
        logic [W-1:0] d;
        logic [3:0]   r;
        s   = model_sel();
        acc = in_valid && model_ready();
        d   = in_data;
        r   = out_ready;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (acc && i == s) begin
                m_valid[i] = 1'b1;
                m_data[i]  = d;
            end else if (m_valid[i] && r[i]) begin
                m_valid[i] = 1'b0;
            end
        end
        if (acc) begin
            m_cnt = (m_cnt + 1) % 256;
            m_rr  = (m_rr + 1) % 4;
        end
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        drive('0, 2'd0, 1'b0, 4'hF);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0000", out_valid);
        end
        n_checks++;
        if (out_data !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", out_data);
        end
        n_checks++;
        if (xfer_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d want 0", xfer_cnt);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single_beat();
        drive(16'h1234, 2'd2, 1'b1, 4'hF);
        tick();
        drive('0, 2'd0, 1'b0, 4'hF);
        n_checks++;
        if (out_valid !== 4'b0100) begin
            n_fail++; $display("FAIL single_valid: got %b want 0100", out_valid);
        end
        n_checks++;
        if (lane(2) !== 16'h1234) begin
            n_fail++; $display("FAIL single_data: got %h want 1234", lane(2));
        end
        tick();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL single_drain: got %b want 0000", out_valid);
        end
        n_checks++;
        if (xfer_cnt !== 8'd1) begin
            n_fail++; $display("FAIL single_cnt: got %0d want 1", xfer_cnt);
        end
    endtask

    task automatic test_backpressure();
        drive(16'hAAAA, 2'd1, 1'b1, 4'b1101);
        tick();
        drive(16'hBBBB, 2'd1, 1'b1, 4'b1101);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid[1] !== 1'b1 || lane(1) !== 16'hAAAA) begin
            n_fail++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=aaaa", out_valid[1], lane(1));
        end
        out_ready = 4'b1111;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_in_ready_high: got %b want 1", in_ready);
        end
        tick();
        drive('0, 2'd0, 1'b0, 4'b1101);
        n_checks++;
        if (out_valid[1] !== 1'b1 || lane(1) !== 16'hBBBB) begin
            n_fail++; $display("FAIL bp_replace: got v=%b d=%h want v=1 d=bbbb", out_valid[1], lane(1));
        end
        out_ready = 4'hF;
        tick();
    endtask

    task automatic test_independent_lanes();
        drive(16'h5555, 2'd0, 1'b1, 4'b1110);
        tick();
        drive(16'h3333, 2'd3, 1'b1, 4'b1110);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL indep_ready_l3: got %b want 1", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid[3] !== 1'b1 || lane(3) !== 16'h3333) begin
            n_fail++; $display("FAIL indep_l3: got v=%b d=%h want v=1 d=3333", out_valid[3], lane(3));
        end
        drive(16'h2222, 2'd2, 1'b1, 4'b1110);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL indep_ready_l2: got %b want 1", in_ready);
        end
        tick();
        drive('0, 2'd0, 1'b0, 4'hF);
        n_checks++;
        if (out_valid !== 4'b0101 || lane(2) !== 16'h2222 || lane(0) !== 16'h5555) begin
            n_fail++; $display("FAIL indep_l2_l0: got v=%b l2=%h l0=%h want v=0101 l2=2222 l0=5555",
                               out_valid, lane(2), lane(0));
        end
        tick();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(W'($urandom), 2'($urandom), 1'b1, 4'hF);
            tick();
            if (i == 254) begin
                n_checks++;
                if (xfer_cnt !== 8'd255) begin
                    n_fail++; $display("FAIL wrap_255: got %0d want 255", xfer_cnt);
                end
            end
            if (i == 255) begin
                n_checks++;
                if (xfer_cnt !== 8'd0) begin
                    n_fail++; $display("FAIL wrap_0: got %0d want 0", xfer_cnt);
                end
            end
        end
        drive('0, 2'd0, 1'b0, 4'hF);
        tick();
    endtask

    task automatic test_async_reset();
        drive(16'hA0A0, 2'd0, 1'b1, 4'b0110);
        tick();
        drive(16'h0B0B, 2'd3, 1'b1, 4'b0110);
        tick();
        drive('0, 2'd0, 1'b0, 4'b0110);
        n_checks++;
        if (out_valid !== 4'b1001) begin
            n_fail++; $display("FAIL arst_pre: got %b want 1001", out_valid);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (out_valid !== 4'b0000 || out_data !== '0) begin
            n_fail++; $display("FAIL arst_clear: got v=%b d=%h want v=0 d=0", out_valid, out_data);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL arst_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 4'hF;
        #1;
    endtask

    task automatic test_auto_sel();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(W'(k), 2'd0, 1'b1, 4'hF);
            tick();
            n_checks++;
            if (out_valid[(k-1)%4] !== 1'b1 || lane((k-1)%4) !== W'(k)) begin
                n_fail++; $display("FAIL auto_order_%0d: got v=%b d=%h in lane %0d want v=1 d=%h",
                                   k, out_valid[(k-1)%4], lane((k-1)%4), (k-1)%4, W'(k));
            end
        end
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(W'(k), 2'd0, 1'b1, 4'b1101);
            tick();
        end
        drive(16'h0006, 2'd0, 1'b1, 4'b1101);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL auto_stall_%0d: got in_ready=%b want 0", c, in_ready);
            end
            tick();
        end
        n_checks++;
        if (lane(0) !== 16'h0005 || lane(1) !== 16'h0002) begin
            n_fail++; $display("FAIL auto_stall_data: got l0=%h l1=%h want l0=0005 l1=0002",
                               lane(0), lane(1));
        end
        out_ready = 4'hF;
        tick();
        drive('0, 2'd0, 1'b0, 4'hF);
        n_checks++;
        if (out_valid[1] !== 1'b1 || lane(1) !== 16'h0006) begin
            n_fail++; $display("FAIL auto_resume: got v=%b d=%h want v=1 d=0006", out_valid[1], lane(1));
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(W'($urandom), 2'($urandom), ($urandom_range(0, 9) < 7), 4'($urandom));
            #1;
            n_checks++;
            if (in_ready !== model_ready()) begin
                n_fail++; $display("FAIL rand_in_ready c=%0d: got %b want %b", c, in_ready, model_ready());
            end
            tick();
            n_checks++;
            if (out_valid !== model_valid_vec()) begin
                n_fail++; $display("FAIL rand_valid c=%0d: got %b want %b", c, out_valid, model_valid_vec());
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (lane(i) !== m_data[i]) begin
                    n_fail++; $display("FAIL rand_data c=%0d lane %0d: got %h want %h", c, i, lane(i), m_data[i]);
                end
            end
            n_checks++;
            if (xfer_cnt !== 8'(m_cnt)) begin
                n_fail++; $display("FAIL rand_cnt c=%0d: got %0d want %0d", c, xfer_cnt, m_cnt);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        drive('0, 2'd0, 1'b0, 4'hF);
        test_reset();
        if (!AUTO) begin
            test_single_beat();
            test_backpressure();
            test_independent_lanes();
        end
        test_counter_wrap();
        if (!AUTO) begin
            test_async_reset();
        end else begin
            test_auto_sel();
        end
        test_random();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
